lemming_world: RTL and testbench
================================

// Module: lemming_world
// PURPOSE
//  Environment model driving the Lemmings-4 walker. Consumes the walker's Moore outputs and produces its
//  ground/bump_left/bump_right/dig inputs from a column-height terrain map. Tracks lemming position (x,y),
//  removes terrain while digging, and drops y while falling. Pairs with the walker in closed-loop benches.
// PARAMETERS
//  WIDTH       16  terrain columns; XW = $clog2(WIDTH)
//  DEPTH       8   max floor height; YW = $clog2(DEPTH+1)
//  INIT_FLOOR  4   floor height of every column after reset (<= DEPTH)
//  START_X     8   lemming column after reset
//  DIG_CYCLES  4   digging cycles needed to remove one terrain row (>= 1)
// PORTS
//  clk         in   1   clock, all state on rising edge
//  reset       in   1   synchronous, active-high reset
//  walk_left   in   1   from walker
//  walk_right  in   1   from walker
//  aaah        in   1   from walker
//  digging     in   1   from walker
//  dig_req     in   1   user dig command
//  wr_en       in   1   terrain write strobe
//  wr_col      in   XW  terrain write column
//  wr_floor    in   YW  terrain write height (values > DEPTH clamp to DEPTH)
//  ground      out  1   to walker
//  bump_left   out  1   to walker
//  bump_right  out  1   to walker
//  dig         out  1   to walker
//  lem_x       out  XW  current column
//  lem_y       out  YW  current height
// BEHAVIOUR
//  Reset (sync): floor[*] = INIT_FLOOR, x = START_X, y = INIT_FLOOR, dig_cnt = 0, dig = 0.
//    Outputs one cycle later: ground = 1, bumps = 0, dig = 0.
//  Outputs:
//    ground, bump_left, bump_right: combinational from registers and walker outputs. No loop, since walker outputs are Moore.
//    dig: registered copy of dig_req (1-cycle latency).
//  ground     = (y == floor[x])
//  bump_left  = walk_left  & ground & (x==0       | floor[x-1] > y)
//  bump_right = walk_right & ground & (x==WIDTH-1 | floor[x+1] > y)
//  Position update per edge (first match wins):
//    aaah & y > floor[x]              -> y <= y-1 (one row per cycle)
//    walk_left & ground & !bump_left  -> x <= x-1 (y unchanged; a lower column yields ground=0 next cycle)
//    walk_right & ground & !bump_right -> x <= x+1
//    else hold.
//  Dig:
//    digging & ground: dig_cnt increments.
//    At dig_cnt == DIG_CYCLES-1: dig_cnt <= 0 and, if floor[x] > 0, floor[x] <= floor[x]-1.
//    Bedrock (floor[x] == 0): terrain unchanged, digging persists.
//    dig_cnt clears whenever digging == 0.
//  Terrain write: floor[wr_col] <= wr_floor.
//    Wins over a same-cycle dig decrement on that column; dig_cnt also clears.
//    If wr_col == x and wr_floor > y, then y <= wr_floor (lemming lifted, no bump).
//  Simultaneous aaah with walk_* or digging is a walker fault: position follows aaah, terrain is untouched.
// CONFIGURATION
//  WORLD_CHECK_EN defined:
//    adds out  fall_len 5 (consecutive aaah cycles, saturating at 31);
//    adds out  proto_err 1 (sticky, cleared only by reset).
//    proto_err sets on:
//      more than one of walk_left/walk_right/aaah/digging high;
//      any walk/dig after a fall of > 20 cycles (splat);
//      walk_* with ground == 0 for 2+ consecutive cycles.
//  WORLD_CHECK_EN undefined: neither port exists, no checker logic.
// STRUCTURE
//  lemming_pkg:
//    SPLAT_LIMIT = 20;
//    typedef enum lem_act_t {ACT_WL, ACT_WR, ACT_FALL, ACT_DIG, ACT_SPLAT}, decoded from walker outputs.
//  Sub-module lemming_terrain:
//    WIDTH x YW register file, one write port plus a dig-decrement port;
//    three combinational reads (x-1, x, x+1), out-of-range reads return DEPTH+1.
// TESTING
//  1 Flat floor 4, start x=8: x steps 8->0 in 8 cycles; bump_left at x=0 for 1 cycle; walker turns; x increments.
//  2 wr floor[5]=6, walking right from x=0: bump_right at x=4, x never reaches 5.
//  3 floor[3]=1, walking left at x=4,y=4: x=3, ground=0, aaah 3 cycles (y 4->1), ground=1, walk_left resumes.
//  4 x=6,floor=4, dig_req pulse: dig 1 cycle later; after 4 digging cycles floor[6]=3; 1 fall cycle; walking resumes at y=3.
//  5 floor[x]=0, dig: digging held 3*DIG_CYCLES cycles, floor stays 0, y stays 0, no ground drop.
//  6 reset asserted mid-fall at y=6: next edge x=START_X, y=INIT_FLOOR, floor map restored, dig=0.
//  7 (WORLD_CHECK_EN, DEPTH=31) drop a column 25->0 under lemming: fall_len reaches 25; proto_err=1 if walker walks afterward.

Source files
------------

// File: rtl/lemming_pkg.sv
// Shared constants and walker-action decode for the lemming world model.
// Optional protocol checker in lemming_world is enabled by defining WORLD_CHECK_EN.
package lemming_pkg;

    localparam int SPLAT_LIMIT = 20;

    typedef enum logic [2:0] {
        ACT_WL,
        ACT_WR,
        ACT_FALL,
        ACT_DIG,
        ACT_SPLAT
    } lem_act_t;

    // The walker's only all-quiet Moore state is splatted; aaah dominates any other output.
    function automatic lem_act_t decode_act(input logic wl, input logic wr,
                                            input logic aaah, input logic dig);
        if (aaah)     return ACT_FALL;
        else if (wl)  return ACT_WL;
        else if (wr)  return ACT_WR;
        else if (dig) return ACT_DIG;
        else          return ACT_SPLAT;
    endfunction

endpackage

// File: rtl/lemming_terrain.sv
// Column-height terrain map: one write port, one dig-decrement port and
// neighbourhood reads around the lemming column (out-of-range reads give DEPTH+1).
module lemming_terrain #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 8,
    parameter int INIT_FLOOR = 4,
    parameter int XW         = 4,
    parameter int YW         = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_wr_en,
    input  logic [XW-1:0] i_wr_col,
    input  logic [YW-1:0] i_wr_floor,
    input  logic          i_dec_en,
    input  logic [XW-1:0] i_x,
    output logic [YW:0]   o_floor_l,
    output logic [YW:0]   o_floor_c,
    output logic [YW:0]   o_floor_r
);

    localparam logic [YW:0] OOR = (YW+1)'(DEPTH + 1);

    logic [YW-1:0] r_floor [WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                r_floor[i] <= INIT_FLOOR[YW-1:0];
            end
        end else begin
            if (i_dec_en && int'(i_x) < WIDTH && r_floor[i_x] != '0) begin
                r_floor[i_x] <= r_floor[i_x] - 1'b1;
            end
            // Later assignment: a write beats a same-cycle dig on the same column.
            if (i_wr_en && int'(i_wr_col) < WIDTH) begin
                r_floor[i_wr_col] <= i_wr_floor;
            end
        end
    end

    always_comb begin
        o_floor_l = OOR;
        o_floor_c = OOR;
        o_floor_r = OOR;
        if (i_x != '0 && int'(i_x) <= WIDTH) begin
            o_floor_l = {1'b0, r_floor[i_x - 1'b1]};
        end
        if (int'(i_x) < WIDTH) begin
            o_floor_c = {1'b0, r_floor[i_x]};
        end
        if (int'(i_x) + 1 < WIDTH) begin
            o_floor_r = {1'b0, r_floor[i_x + 1'b1]};
        end
    end

endmodule

// File: rtl/lemming_world.sv
// Environment model for the Lemmings-4 walker: terrain, position, digging and falling.
// Define WORLD_CHECK_EN to add the fall_len / proto_err walker-protocol checker.
module lemming_world
    import lemming_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 8,
    parameter int INIT_FLOOR = 4,
    parameter int START_X    = 8,
    parameter int DIG_CYCLES = 4,
    localparam int XW        = $clog2(WIDTH),
    localparam int YW        = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          walk_left,
    input  logic          walk_right,
    input  logic          aaah,
    input  logic          digging,
    input  logic          dig_req,
    input  logic          wr_en,
    input  logic [XW-1:0] wr_col,
    input  logic [YW-1:0] wr_floor,
    output logic          ground,
    output logic          bump_left,
    output logic          bump_right,
    output logic          dig,
`ifdef WORLD_CHECK_EN
    output logic [4:0]    fall_len,
    output logic          proto_err,
`endif
    output logic [XW-1:0] lem_x,
    output logic [YW-1:0] lem_y
);

    localparam int CW = (DIG_CYCLES > 1) ? $clog2(DIG_CYCLES) : 1;

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [CW-1:0] r_dig_cnt;
    logic          r_dig;

    logic [YW:0]   w_floor_l;
    logic [YW:0]   w_floor_c;
    logic [YW:0]   w_floor_r;
    logic [YW:0]   w_y_ext;
    logic [YW-1:0] w_wr_floor;
    logic          w_ground;
    logic          w_bump_left;
    logic          w_bump_right;
    logic          w_wr_hit;
    logic          w_lift;
    logic          w_dig_step;
    logic          w_dig_wrap;
    lem_act_t      w_act;

    assign w_act        = decode_act(walk_left, walk_right, aaah, digging);
    assign w_y_ext      = {1'b0, r_y};
    assign w_wr_floor   = (int'(wr_floor) > DEPTH) ? YW'(DEPTH) : wr_floor;
    assign w_ground     = (w_y_ext == w_floor_c);
    assign w_bump_left  = walk_left & w_ground & ((r_x == '0) | (w_floor_l > w_y_ext));
    assign w_bump_right = walk_right & w_ground &
                          ((int'(r_x) == WIDTH - 1) | (w_floor_r > w_y_ext));
    assign w_wr_hit     = wr_en & (wr_col == r_x);
    assign w_lift       = w_wr_hit & (w_wr_floor > r_y);
    // A falling walker that also claims to dig must not touch the terrain.
    assign w_dig_step   = digging & ~aaah & w_ground;
    assign w_dig_wrap   = (r_dig_cnt == CW'(DIG_CYCLES - 1));

    lemming_terrain #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .INIT_FLOOR (INIT_FLOOR),
        .XW         (XW),
        .YW         (YW)
    ) u_terrain (
        .clk        (clk),
        .reset      (reset),
        .i_wr_en    (wr_en),
        .i_wr_col   (wr_col),
        .i_wr_floor (w_wr_floor),
        .i_dec_en   (w_dig_step & w_dig_wrap),
        .i_x        (r_x),
        .o_floor_l  (w_floor_l),
        .o_floor_c  (w_floor_c),
        .o_floor_r  (w_floor_r)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x       <= START_X[XW-1:0];
            r_y       <= INIT_FLOOR[YW-1:0];
            r_dig_cnt <= '0;
            r_dig     <= 1'b0;
        end else begin
            r_dig <= dig_req;

            case (w_act)
                ACT_FALL: if (w_y_ext > w_floor_c)          r_y <= r_y - 1'b1;
                ACT_WL:   if (w_ground && !w_bump_left)     r_x <= r_x - 1'b1;
                ACT_WR:   if (w_ground && !w_bump_right)    r_x <= r_x + 1'b1;
                default:  ;
            endcase

            if (w_lift) begin
                r_y <= w_wr_floor;
            end

            if (!digging || w_wr_hit) begin
                r_dig_cnt <= '0;
            end else if (w_dig_step) begin
                r_dig_cnt <= w_dig_wrap ? '0 : r_dig_cnt + 1'b1;
            end
        end
    end

    assign ground     = w_ground;
    assign bump_left  = w_bump_left;
    assign bump_right = w_bump_right;
    assign dig        = r_dig;
    assign lem_x      = r_x;
    assign lem_y      = r_y;

`ifdef WORLD_CHECK_EN
    logic [4:0] r_fall_len;
    logic       r_proto_err;
    logic       r_aaah_d;
    logic       r_nog_walk;
    logic [2:0] w_n_act;
    logic       w_walk;
    logic       w_splat_move;

    assign w_n_act      = 3'(walk_left) + 3'(walk_right) + 3'(aaah) + 3'(digging);
    assign w_walk       = walk_left | walk_right;
    // fall_len holds after landing, so any later walk/dig after a long fall is caught.
    assign w_splat_move = ~aaah & (r_fall_len > 5'(SPLAT_LIMIT)) & (w_walk | digging);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fall_len  <= '0;
            r_proto_err <= 1'b0;
            r_aaah_d    <= 1'b0;
            r_nog_walk  <= 1'b0;
        end else begin
            r_aaah_d   <= aaah;
            r_nog_walk <= w_walk & ~w_ground;
            if (aaah) begin
                if (!r_aaah_d)              r_fall_len <= 5'd1;
                else if (r_fall_len != '1)  r_fall_len <= r_fall_len + 1'b1;
            end
            if (w_n_act > 3'd1 || w_splat_move || (w_walk && !w_ground && r_nog_walk)) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign fall_len  = r_fall_len;
    assign proto_err = r_proto_err;
`endif

endmodule

// File: tb/tb_lemming_world.sv
// Scoreboard bench for lemming_world: each row drives walker/terrain inputs and
// queues the expected position/sensor outputs, popped and compared after the edge.
module tb_lemming_world;

`ifdef WORLD_CHECK_EN
    localparam int DEPTH = 31;
`else
    localparam int DEPTH = 8;
`endif
    localparam int WIDTH = 16;
    localparam int XW    = $clog2(WIDTH);
    localparam int YW    = $clog2(DEPTH + 1);
    localparam int LIFT  = (15 > DEPTH) ? DEPTH : 15;

    typedef struct packed {
        logic [3:0] x;
        logic [5:0] y;
        logic       g;
        logic       bl;
        logic       br;
        logic       d;
    } obs_t;

    typedef struct packed {
        logic       rst;
        logic       wl;
        logic       wr;
        logic       aa;
        logic       dg;
        logic       dq;
        logic       wen;
        logic [3:0] wc;
        logic [5:0] wf;
        obs_t       e;
    } row_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          walk_left, walk_right, aaah, digging, dig_req, wr_en;
    logic [XW-1:0] wr_col;
    logic [YW-1:0] wr_floor;
    logic          ground, bump_left, bump_right, dig;
    logic [XW-1:0] lem_x;
    logic [YW-1:0] lem_y;
`ifdef WORLD_CHECK_EN
    logic [4:0]    fall_len;
    logic          proto_err;
`endif

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    lemming_world #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .INIT_FLOOR (4),
        .START_X    (8),
        .DIG_CYCLES (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .walk_left  (walk_left),
        .walk_right (walk_right),
        .aaah       (aaah),
        .digging    (digging),
        .dig_req    (dig_req),
        .wr_en      (wr_en),
        .wr_col     (wr_col),
        .wr_floor   (wr_floor),
        .ground     (ground),
        .bump_left  (bump_left),
        .bump_right (bump_right),
        .dig        (dig),
`ifdef WORLD_CHECK_EN
        .fall_len   (fall_len),
        .proto_err  (proto_err),
`endif
        .lem_x      (lem_x),
        .lem_y      (lem_y)
    );

    always #5 clk = ~clk;

    function automatic row_t r(input logic rst, input logic wl, input logic wr,
                               input logic aa, input logic dg, input logic dq,
                               input logic wen, input int wc, input int wf,
                               input int x, input int y, input logic g,
                               input logic bl, input logic br, input logic d);
        row_t t;
        t.rst = rst; t.wl = wl; t.wr = wr; t.aa = aa; t.dg = dg; t.dq = dq;
        t.wen = wen; t.wc = 4'(wc); t.wf = 6'(wf);
        t.e.x = 4'(x); t.e.y = 6'(y); t.e.g = g; t.e.bl = bl; t.e.br = br; t.e.d = d;
        return t;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.x = 4'(lem_x); o.y = 6'(lem_y); o.g = ground;
        o.bl = bump_left; o.br = bump_right; o.d = dig;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("x=%0d y=%0d ground=%b bl=%b br=%b dig=%b", o.x, o.y, o.g, o.bl, o.br, o.d);
    endfunction

    // Drives one row's stimulus and queues what the DUT must show after the next edge.
    task automatic apply(input row_t t);
        reset = t.rst; walk_left = t.wl; walk_right = t.wr; aaah = t.aa;
        digging = t.dg; dig_req = t.dq; wr_en = t.wen;
        wr_col = t.wc[XW-1:0]; wr_floor = t.wf[YW-1:0];
        exp_q.push_back(t.e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        row_t rows[$];
        obs_t got, e;
        rows.push_back(r(1,0,0,0,0,0, 0,0,0, 8,4,1,0,0,0));
        rows.push_back(r(1,0,0,0,0,1, 0,0,0, 8,4,1,0,0,0));
        foreach (rows[i]) begin
            apply(rows[i]); tick();
            got = sample(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset step %0d: got %s, expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_walk_left();
        row_t rows[$];
        obs_t got, e;
        for (int k = 7; k >= 0; k--) rows.push_back(r(0,1,0,0,0,0, 0,0,0, k,4,1,(k == 0),0,0));
        rows.push_back(r(0,1,0,0,0,0, 0,0,0, 0,4,1,1,0,0));
        rows.push_back(r(0,0,1,0,0,0, 0,0,0, 1,4,1,0,0,0));
        rows.push_back(r(0,0,1,0,0,0, 0,0,0, 2,4,1,0,0,0));
        foreach (rows[i]) begin
            apply(rows[i]); tick();
            got = sample(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL walk_left step %0d: got %s, expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_bump_right();
        row_t rows[$];
        obs_t got, e;
        rows.push_back(r(0,0,0,0,0,0, 1,5,6, 2,4,1,0,0,0));
        rows.push_back(r(0,1,0,0,0,0, 0,0,0, 1,4,1,0,0,0));
        rows.push_back(r(0,1,0,0,0,0, 0,0,0, 0,4,1,1,0,0));
        rows.push_back(r(0,0,1,0,0,0, 0,0,0, 1,4,1,0,0,0));
        rows.push_back(r(0,0,1,0,0,0, 0,0,0, 2,4,1,0,0,0));
        rows.push_back(r(0,0,1,0,0,0, 0,0,0, 3,4,1,0,0,0));
        rows.push_back(r(0,0,1,0,0,0, 0,0,0, 4,4,1,0,1,0));
        rows.push_back(r(0,0,1,0,0,0, 0,0,0, 4,4,1,0,1,0));
        foreach (rows[i]) begin
            apply(rows[i]); tick();
            got = sample(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL bump_right step %0d: got %s, expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_fall();
        row_t rows[$];
        obs_t got, e;
        rows.push_back(r(0,0,0,0,0,0, 1,3,1, 4,4,1,0,0,0));
        rows.push_back(r(0,1,0,0,0,0, 0,0,0, 3,4,0,0,0,0));
        rows.push_back(r(0,0,0,1,0,0, 0,0,0, 3,3,0,0,0,0));
        rows.push_back(r(0,0,0,1,0,0, 0,0,0, 3,2,0,0,0,0));
        rows.push_back(r(0,0,0,1,0,0, 0,0,0, 3,1,1,0,0,0));
        rows.push_back(r(0,1,0,0,0,0, 0,0,0, 3,1,1,1,0,0));
        rows.push_back(r(0,0,1,1,0,0, 0,0,0, 3,1,1,0,1,0));
        foreach (rows[i]) begin
            apply(rows[i]); tick();
            got = sample(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL fall step %0d: got %s, expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_dig();
        row_t rows[$];
        obs_t got, e;
        rows.push_back(r(1,0,0,0,0,0, 0,0,0, 8,4,1,0,0,0));
        rows.push_back(r(0,1,0,0,0,0, 0,0,0, 7,4,1,0,0,0));
        rows.push_back(r(0,1,0,0,0,0, 0,0,0, 6,4,1,0,0,0));
        rows.push_back(r(0,0,0,0,0,1, 0,0,0, 6,4,1,0,0,1));
        rows.push_back(r(0,0,0,0,0,0, 0,0,0, 6,4,1,0,0,0));
        for (int k = 0; k < 3; k++) rows.push_back(r(0,0,0,0,1,0, 0,0,0, 6,4,1,0,0,0));
        rows.push_back(r(0,0,0,0,1,0, 0,0,0, 6,4,0,0,0,0));
        rows.push_back(r(0,0,0,1,0,0, 0,0,0, 6,3,1,0,0,0));
        rows.push_back(r(0,1,0,0,0,0, 0,0,0, 6,3,1,1,0,0));
        foreach (rows[i]) begin
            apply(rows[i]); tick();
            got = sample(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL dig step %0d: got %s, expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_bedrock();
        row_t rows[$];
        obs_t got, e;
        rows.push_back(r(0,0,0,0,0,0, 1,6,0, 6,3,0,0,0,0));
        rows.push_back(r(0,0,0,1,0,0, 0,0,0, 6,2,0,0,0,0));
        rows.push_back(r(0,0,0,1,0,0, 0,0,0, 6,1,0,0,0,0));
        rows.push_back(r(0,0,0,1,0,0, 0,0,0, 6,0,1,0,0,0));
        for (int k = 0; k < 12; k++) rows.push_back(r(0,0,0,0,1,0, 0,0,0, 6,0,1,0,0,0));
        // Write of 15 clamps to DEPTH, lifts the lemming and restarts the dig count.
        rows.push_back(r(0,0,0,0,1,0, 1,6,15, 6,LIFT,1,0,0,0));
        for (int k = 0; k < 3; k++) rows.push_back(r(0,0,0,0,1,0, 0,0,0, 6,LIFT,1,0,0,0));
        rows.push_back(r(0,0,0,0,1,0, 0,0,0, 6,LIFT,0,0,0,0));
        foreach (rows[i]) begin
            apply(rows[i]); tick();
            got = sample(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL bedrock step %0d: got %s, expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_reset_mid_fall();
        row_t rows[$];
        obs_t got, e;
        rows.push_back(r(0,0,0,0,0,0, 1,6,2, 6,LIFT,0,0,0,0));
        rows.push_back(r(0,0,0,1,0,0, 0,0,0, 6,LIFT-1,0,0,0,0));
        rows.push_back(r(0,0,0,1,0,0, 0,0,0, 6,LIFT-2,0,0,0,0));
        rows.push_back(r(1,0,0,1,0,1, 0,0,0, 8,4,1,0,0,0));
        rows.push_back(r(0,1,0,0,0,0, 0,0,0, 7,4,1,0,0,0));
        rows.push_back(r(0,1,0,0,0,0, 0,0,0, 6,4,1,0,0,0));
        rows.push_back(r(0,1,0,0,0,0, 0,0,0, 5,4,1,0,0,0));
        foreach (rows[i]) begin
            apply(rows[i]); tick();
            got = sample(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset_mid_fall step %0d: got %s, expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        obs_t got, e;
        logic [4:0] pat;
        pat = 5'b01011;
        for (int k = 0; k < 5; k++) rows.push_back(r(0,0,0,0,0,pat[k], 0,0,0, 5,4,1,0,0,pat[k]));
        foreach (rows[i]) begin
            apply(rows[i]); tick();
            got = sample(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL back_to_back step %0d: got %s, expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask

`ifdef WORLD_CHECK_EN
    task automatic test_world_check();
        row_t rows[$];
        obs_t got, e;
        rows.push_back(r(1,0,0,0,0,0, 0,0,0, 8,4,1,0,0,0));
        rows.push_back(r(0,0,0,0,0,0, 1,8,25, 8,25,1,0,0,0));
        rows.push_back(r(0,0,0,0,0,0, 1,8,0, 8,25,0,0,0,0));
        for (int k = 24; k >= 0; k--) rows.push_back(r(0,0,0,1,0,0, 0,0,0, 8,k,(k == 0),0,0,0));
        foreach (rows[i]) begin
            apply(rows[i]); tick();
            got = sample(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL world_check step %0d: got %s, expected %s", i, fmt(got), fmt(e));
            end
        end
        n_checks++;
        if (fall_len !== 5'd25 || proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL fall_len: got len=%0d err=%b, expected len=25 err=0", fall_len, proto_err);
        end
        apply(r(0,1,0,0,0,0, 0,0,0, 8,0,1,1,0,0)); tick();
        got = sample(); e = exp_q.pop_front(); n_checks++;
        if (got !== e || proto_err !== 1'b1) begin
            n_fail++;
            $display("FAIL splat_walk: got %s err=%b, expected %s err=1", fmt(got), proto_err, fmt(e));
        end
    endtask
`endif

    initial begin
        reset = 1'b1; walk_left = 1'b0; walk_right = 1'b0; aaah = 1'b0;
        digging = 1'b0; dig_req = 1'b0; wr_en = 1'b0; wr_col = '0; wr_floor = '0;
        test_reset();
        test_walk_left();
        test_bump_right();
        test_fall();
        test_dig();
        test_bedrock();
        test_reset_mid_fall();
        test_back_to_back();
`ifdef WORLD_CHECK_EN
        test_world_check();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
